// File: rtl/lcu_cmd_queue_if.sv
// Command handshake between lcu_cmd_queue (producer) and the executor (consumer).
interface lcu_cmd_queue_if #(
    parameter int W    = 23,
    parameter int TAGW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [W-1:0]    cmd_data;
    logic [TAGW-1:0] cmd_tag;

    modport master (
        output cmd_valid,
        output cmd_data,
        output cmd_tag,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_tag,
        output cmd_ready
    );
endinterface

// File: rtl/lcu_cmd_queue.sv
// Queues each new non-zero lcu control word with a sequence tag; show-ahead
// valid/ready drain, sticky overflow and saturating drop statistics.
module lcu_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 23,
    parameter int TAGW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [W-1:0]           y_vec,
    lcu_cmd_queue_if.master        cmd,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]      prev;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [TAGW-1:0]   tag_ctr;
    logic [TAGW+W-1:0] mem [DEPTH];
    logic [TAGW+W-1:0] head;

    logic          push_req;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [LW-1:0] level_nxt;

    always_comb begin
        push_req = (y_vec != '0) && (y_vec != prev);
        full     = (level == FULL_LVL);
        empty    = (level == '0);
        pop      = !empty && cmd.cmd_ready;
        // A full queue still accepts when the head leaves on the same edge.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        case ({push_ok, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_ctr    <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr) begin
            prev       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_ctr    <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            prev  <= y_vec;
            level <= level_nxt;
            if (push_ok) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_ctr <= tag_ctr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; entries are only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (rst && !clr && push_ok) begin
            mem[wr_ptr] <= {tag_ctr, y_vec};
        end
    end

    always_comb begin
        head          = mem[rd_ptr];
        cmd.cmd_valid = !empty;
        cmd.cmd_data  = empty ? '0 : head[W-1:0];
        cmd.cmd_tag   = empty ? '0 : head[TAGW+W-1:W];
    end
endmodule
